// File: rtl/h264_quantiser_if.sv
// Stream interface between the forward transform, the quantiser and the CAVLC stage.
// With QUANT_DC_BYPASS_EN defined it also carries DCBYPASS and DCOUT.
interface h264_quantiser_if #(
   parameter int IN_WIDTH  = 14,
   parameter int OUT_WIDTH = 13
);
   logic [5:0]           QP;
   logic                 INTRA;
   logic                 ENABLE;
   logic [IN_WIDTH-1:0]  YNIN;
   logic                 VALID;
   logic [OUT_WIDTH-1:0] ZOUT;
   logic                 ZLAST;
   logic [4:0]           NZCOUNT;
`ifdef QUANT_DC_BYPASS_EN
   logic                 DCBYPASS;
   logic [IN_WIDTH-1:0]  DCOUT;

   modport master (output QP, INTRA, ENABLE, YNIN, DCBYPASS,
                   input  VALID, ZOUT, ZLAST, NZCOUNT, DCOUT);
   modport slave  (input  QP, INTRA, ENABLE, YNIN, DCBYPASS,
                   output VALID, ZOUT, ZLAST, NZCOUNT, DCOUT);
`else
   modport master (output QP, INTRA, ENABLE, YNIN,
                   input  VALID, ZOUT, ZLAST, NZCOUNT);
   modport slave  (input  QP, INTRA, ENABLE, YNIN,
                   output VALID, ZOUT, ZLAST, NZCOUNT);
`endif
endinterface

// File: rtl/h264_quantiser.sv
// H.264 4x4 forward quantiser: 3-stage pipeline (select MF/f, multiply-add, shift/sign/count).
// Optional QUANT_DC_BYPASS_EN: the zigzag-0 beat of a bypassed block goes raw to DCOUT.
module h264_quantiser #(
   parameter int IN_WIDTH  = 14,
   parameter int OUT_WIDTH = 13
) (
   input  logic            CLK,
   input  logic            RESET,
   h264_quantiser_if.slave bus
);

   localparam int PW = (IN_WIDTH + 15 > 26) ? IN_WIDTH + 15 : 26;

   function automatic logic [1:0] pos_class(input logic [3:0] zz);
      case (zz)
         4'd0, 4'd3, 4'd5, 4'd11:   pos_class = 2'd0;
         4'd4, 4'd10, 4'd12, 4'd15: pos_class = 2'd1;
         default:                   pos_class = 2'd2;
      endcase
   endfunction

   function automatic logic [13:0] mf_lookup(input logic [2:0] rem, input logic [1:0] cls);
      logic [13:0] mf_a;
      logic [13:0] mf_b;
      logic [13:0] mf_c;
      case (rem)
         3'd1:    begin mf_a = 14'd11916; mf_b = 14'd4660; mf_c = 14'd7490; end
         3'd2:    begin mf_a = 14'd10082; mf_b = 14'd4194; mf_c = 14'd6554; end
         3'd3:    begin mf_a = 14'd9362;  mf_b = 14'd3647; mf_c = 14'd5825; end
         3'd4:    begin mf_a = 14'd8192;  mf_b = 14'd3355; mf_c = 14'd5243; end
         3'd5:    begin mf_a = 14'd7282;  mf_b = 14'd2893; mf_c = 14'd4559; end
         default: begin mf_a = 14'd13107; mf_b = 14'd5243; mf_c = 14'd8066; end
      endcase
      case (cls)
         2'd0:    mf_lookup = mf_a;
         2'd1:    mf_lookup = mf_b;
         default: mf_lookup = mf_c;
      endcase
   endfunction

   // floor(2^(14+m)/3): intra uses m = qp/6 + 1, inter m = qp/6, since floor(2^q/6) = floor(2^(q-1)/3)
   function automatic logic [23:0] offset_lookup(input logic [3:0] m);
      case (m)
         4'd0:    offset_lookup = 24'd5461;
         4'd1:    offset_lookup = 24'd10922;
         4'd2:    offset_lookup = 24'd21845;
         4'd3:    offset_lookup = 24'd43690;
         4'd4:    offset_lookup = 24'd87381;
         4'd5:    offset_lookup = 24'd174762;
         4'd6:    offset_lookup = 24'd349525;
         4'd7:    offset_lookup = 24'd699050;
         4'd8:    offset_lookup = 24'd1398101;
         4'd9:    offset_lookup = 24'd2796202;
         4'd10:   offset_lookup = 24'd5592405;
         4'd11:   offset_lookup = 24'd11184810;
         default: offset_lookup = 24'd0;
      endcase
   endfunction

   logic [3:0]           beat_q, beat_d;
   logic [5:0]           qp_q, qp_d;
   logic                 intra_q, intra_d;
   logic                 byp_q, byp_d;
   logic                 byp_in_s;

   logic                 first_s, intra_eff_s, byp_eff_s;
   logic [5:0]           qp_eff_s;
   logic [3:0]           qdiv_s, zz_s;
   logic [2:0]           qrem_s;

   logic                 s1_valid_q, s1_valid_d, s1_neg_q, s1_neg_d, s1_last_q, s1_last_d;
   logic                 s1_dcbyp_q, s1_dcbyp_d;
   logic [IN_WIDTH-1:0]  s1_abs_q, s1_abs_d;
   logic [13:0]          s1_mf_q, s1_mf_d;
   logic [23:0]          s1_f_q, s1_f_d;
   logic [4:0]           s1_qbits_q, s1_qbits_d;

   logic                 s2_valid_q, s2_valid_d, s2_neg_q, s2_neg_d, s2_last_q, s2_last_d;
   logic                 s2_dcbyp_q, s2_dcbyp_d;
   logic [PW-1:0]        s2_sum_q, s2_sum_d;
   logic [4:0]           s2_qbits_q, s2_qbits_d;

   logic [OUT_WIDTH-1:0] mag_s, lvl_s;
   logic                 nz_s;
   logic                 valid_q, valid_d, zlast_q, zlast_d;
   logic [OUT_WIDTH-1:0] zout_q, zout_d;
   logic [4:0]           nzcount_q, nzcount_d, nzacc_q, nzacc_d;

`ifdef QUANT_DC_BYPASS_EN
   assign byp_in_s = bus.DCBYPASS;
`else
   assign byp_in_s = 1'b0;
`endif

   always_comb begin
      first_s     = (beat_q == 4'd0);
      qp_eff_s    = first_s ? bus.QP    : qp_q;
      intra_eff_s = first_s ? bus.INTRA : intra_q;
      byp_eff_s   = first_s ? byp_in_s  : byp_q;
      qdiv_s      = 4'(qp_eff_s / 6'd6);
      qrem_s      = 3'(qp_eff_s - ({2'b00, qdiv_s} * 6'd6));
      zz_s        = 4'd15 - beat_q;

      beat_d  = beat_q;
      qp_d    = qp_q;
      intra_d = intra_q;
      byp_d   = byp_q;
      if (bus.ENABLE) begin
         beat_d  = beat_q + 4'd1;
         qp_d    = qp_eff_s;
         intra_d = intra_eff_s;
         byp_d   = byp_eff_s;
      end else begin
         beat_d  = beat_q;
      end

      s1_valid_d = bus.ENABLE;
      s1_neg_d   = bus.YNIN[IN_WIDTH-1];
      s1_abs_d   = s1_neg_d ? (~bus.YNIN + {{(IN_WIDTH-1){1'b0}}, 1'b1}) : bus.YNIN;
      s1_mf_d    = mf_lookup(qrem_s, pos_class(zz_s));
      s1_f_d     = offset_lookup(qdiv_s + {3'd0, intra_eff_s});
      s1_qbits_d = 5'd15 + {1'b0, qdiv_s};
      s1_last_d  = (beat_q == 4'd15);
      s1_dcbyp_d = byp_eff_s && (beat_q == 4'd15);

      s2_valid_d = s1_valid_q;
      s2_sum_d   = (PW'(s1_abs_q) * PW'(s1_mf_q)) + PW'(s1_f_q);
      s2_neg_d   = s1_neg_q;
      s2_qbits_d = s1_qbits_q;
      s2_last_d  = s1_last_q;
      s2_dcbyp_d = s1_dcbyp_q;

      mag_s = OUT_WIDTH'(s2_sum_q >> s2_qbits_q);
      if (s2_dcbyp_q) begin
         lvl_s = {OUT_WIDTH{1'b0}};
      end else if (s2_neg_q) begin
         lvl_s = ~mag_s + {{(OUT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         lvl_s = mag_s;
      end
      nz_s = (lvl_s != {OUT_WIDTH{1'b0}});

      valid_d   = s2_valid_q;
      zout_d    = zout_q;
      zlast_d   = 1'b0;
      nzcount_d = nzcount_q;
      nzacc_d   = nzacc_q;
      if (s2_valid_q) begin
         zout_d  = lvl_s;
         zlast_d = s2_last_q;
         if (s2_last_q) begin
            nzcount_d = nzacc_q + {4'd0, nz_s};
            nzacc_d   = 5'd0;
         end else begin
            nzacc_d   = nzacc_q + {4'd0, nz_s};
         end
      end else begin
         zout_d = zout_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         beat_q     <= 4'd0;
         qp_q       <= 6'd0;
         intra_q    <= 1'b0;
         byp_q      <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_neg_q   <= 1'b0;
         s1_abs_q   <= {IN_WIDTH{1'b0}};
         s1_mf_q    <= 14'd0;
         s1_f_q     <= 24'd0;
         s1_qbits_q <= 5'd0;
         s1_last_q  <= 1'b0;
         s1_dcbyp_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_sum_q   <= {PW{1'b0}};
         s2_neg_q   <= 1'b0;
         s2_qbits_q <= 5'd0;
         s2_last_q  <= 1'b0;
         s2_dcbyp_q <= 1'b0;
         valid_q    <= 1'b0;
         zout_q     <= {OUT_WIDTH{1'b0}};
         zlast_q    <= 1'b0;
         nzcount_q  <= 5'd0;
         nzacc_q    <= 5'd0;
      end else begin
         beat_q     <= beat_d;
         qp_q       <= qp_d;
         intra_q    <= intra_d;
         byp_q      <= byp_d;
         s1_valid_q <= s1_valid_d;
         s1_neg_q   <= s1_neg_d;
         s1_abs_q   <= s1_abs_d;
         s1_mf_q    <= s1_mf_d;
         s1_f_q     <= s1_f_d;
         s1_qbits_q <= s1_qbits_d;
         s1_last_q  <= s1_last_d;
         s1_dcbyp_q <= s1_dcbyp_d;
         s2_valid_q <= s2_valid_d;
         s2_sum_q   <= s2_sum_d;
         s2_neg_q   <= s2_neg_d;
         s2_qbits_q <= s2_qbits_d;
         s2_last_q  <= s2_last_d;
         s2_dcbyp_q <= s2_dcbyp_d;
         valid_q    <= valid_d;
         zout_q     <= zout_d;
         zlast_q    <= zlast_d;
         nzcount_q  <= nzcount_d;
         nzacc_q    <= nzacc_d;
      end
   end

`ifdef QUANT_DC_BYPASS_EN
   logic [IN_WIDTH-1:0] s1_raw_q, s2_raw_q, dcout_q;

   // Raw DC travels alongside the arithmetic so DCOUT updates with its beat
   always_ff @(posedge CLK) begin
      if (RESET) begin
         s1_raw_q <= {IN_WIDTH{1'b0}};
         s2_raw_q <= {IN_WIDTH{1'b0}};
         dcout_q  <= {IN_WIDTH{1'b0}};
      end else begin
         s1_raw_q <= bus.YNIN;
         s2_raw_q <= s1_raw_q;
         if (s2_valid_q && s2_dcbyp_q) begin
            dcout_q <= s2_raw_q;
         end else begin
            dcout_q <= dcout_q;
         end
      end
   end

   assign bus.DCOUT = dcout_q;
`endif

   assign bus.VALID   = valid_q;
   assign bus.ZOUT    = zout_q;
   assign bus.ZLAST   = zlast_q;
   assign bus.NZCOUNT = nzcount_q;

endmodule

// File: tb/tb_h264_quantiser.sv
// Scoreboard bench for h264_quantiser: an integer reference model queues expected levels per beat.
module tb_h264_quantiser;
   localparam int IN_W  = 14;
   localparam int OUT_W = 13;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   h264_quantiser_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus();
   h264_quantiser #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   typedef struct {
      longint z;
      bit     last;
      int     nz;
      longint dc;
      int     cyc;
   } exp_t;

   int mf_tab [6][3] = '{'{13107, 5243, 8066}, '{11916, 4660, 7490}, '{10082, 4194, 6554},
                         '{9362, 3647, 5825},  '{8192, 3355, 5243},  '{7282, 2893, 4559}};

   exp_t   sb_q[$];
   exp_t   mon_e;
   int     n_checks = 0;
   int     n_errors = 0;
   int     cyc_cnt  = 0;
   longint last_z   = 0;
   int     m_beat = 0, m_qp = 0, m_nz = 0;
   bit     m_intra = 1'b0, m_byp = 1'b0;
   longint m_dc = 0;
   int     blk_w[16];

   task automatic check_value(input string tag, input longint obs, input longint exp_v);
      n_checks++;
      if (obs != exp_v) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic int pos_cls(input int zz);
      if (zz inside {0, 3, 5, 11}) return 0;
      else if (zz inside {4, 10, 12, 15}) return 1;
      else return 2;
   endfunction

   always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

   // Output monitor: pops one expectation per VALID beat
   always @(negedge CLK) begin
      if (RESET) begin
         last_z = 0;
      end else if (bus.VALID) begin
         if (sb_q.size() == 0) begin
            check_value("spurious_valid", 1, 0);
         end else begin
            mon_e = sb_q.pop_front();
            check_value("zout", $signed(bus.ZOUT), mon_e.z);
            check_value("zlast", bus.ZLAST, mon_e.last);
            check_value("latency", cyc_cnt, mon_e.cyc);
            if (mon_e.last) check_value("nzcount", bus.NZCOUNT, mon_e.nz);
`ifdef QUANT_DC_BYPASS_EN
            check_value("dcout", $signed(bus.DCOUT), mon_e.dc);
`endif
            last_z = mon_e.z;
         end
      end else begin
         check_value("zout_hold", $signed(bus.ZOUT), last_z);
      end
   end

   task automatic send_beat(input int w);
      exp_t   x;
      int     qb;
      longint f, aw, mag;
      if (m_beat == 0) begin
         m_qp    = int'(bus.QP);
         m_intra = bus.INTRA;
`ifdef QUANT_DC_BYPASS_EN
         m_byp   = bus.DCBYPASS;
`endif
      end
      qb  = 15 + m_qp / 6;
      f   = (longint'(1) << qb) / (m_intra ? 3 : 6);
      aw  = (w < 0) ? -w : w;
      mag = (aw * mf_tab[m_qp % 6][pos_cls(15 - m_beat)] + f) >> qb;
      x.z    = (w < 0) ? -mag : mag;
      x.last = (m_beat == 15);
      if (m_byp && x.last) begin
         x.z  = 0;
         m_dc = w;
      end
      if (x.z != 0) m_nz++;
      x.nz  = m_nz;
      x.dc  = m_dc;
      x.cyc = cyc_cnt + 3;
      if (x.last) m_nz = 0;
      m_beat = (m_beat + 1) % 16;
      sb_q.push_back(x);
      bus.ENABLE = 1'b1;
      bus.YNIN   = IN_W'(w);
      @(posedge CLK);
      #1;
      bus.ENABLE = 1'b0;
   endtask

   task automatic send_block(input int qp, input bit intra, input int gap, input int alt_at);
      for (int k = 0; k < 16; k++) begin
         if (k == 0) begin
            bus.QP    = 6'(qp);
            bus.INTRA = intra;
         end
         if (k == alt_at) begin
            bus.QP    = 6'd0;
            bus.INTRA = ~intra;
         end
         send_beat(blk_w[k]);
         repeat (gap) begin
            @(posedge CLK);
            #1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #1;
      RESET = 1'b1;
      sb_q.delete();
      m_beat = 0; m_qp = 0; m_nz = 0; m_intra = 1'b0; m_byp = 1'b0; m_dc = 0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      check_value("rst_valid", bus.VALID, 0);
      check_value("rst_zout", bus.ZOUT, 0);
      check_value("rst_zlast", bus.ZLAST, 0);
      check_value("rst_nzcount", bus.NZCOUNT, 0);
   endtask

   task automatic fill_dc_only(input int w15);
      for (int k = 0; k < 16; k++) blk_w[k] = 0;
      blk_w[15] = w15;
   endtask

   task automatic fill_random();
      for (int k = 0; k < 16; k++) blk_w[k] = int'($urandom_range(0, 16383)) - 8192;
   endtask

   initial begin
      bus.ENABLE = 1'b0;
      bus.YNIN   = '0;
      bus.QP     = 6'd0;
      bus.INTRA  = 1'b0;
`ifdef QUANT_DC_BYPASS_EN
      bus.DCBYPASS = 1'b0;
`endif
      do_reset();

      fill_dc_only(0);     send_block(0, 1'b1, 0, -1);
      fill_dc_only(100);   send_block(0, 1'b1, 0, -1);
      fill_dc_only(-100);  send_block(0, 1'b1, 0, -1);
      fill_dc_only(-8192); send_block(0, 1'b1, 0, -1);
      fill_dc_only(7);     send_block(0, 1'b1, 0, -1);
      fill_dc_only(7);     send_block(0, 1'b0, 0, -1);

      fill_random(); blk_w[15] = 1000;
      send_block(28, 1'b1, 0, 5);

      fill_random(); send_block(int'($urandom_range(0, 51)), 1'b1, 0, -1);
      fill_random(); send_block(int'($urandom_range(0, 51)), 1'b0, 0, -1);
      fill_random(); send_block(int'($urandom_range(0, 51)), 1'b1, 3, -1);
      fill_random(); send_block(51, 1'b0, 3, -1);

      fill_random();
      bus.QP = 6'd12; bus.INTRA = 1'b1;
      for (int k = 0; k < 8; k++) send_beat(blk_w[k]);
      do_reset();
      fill_random(); send_block(6, 1'b1, 0, -1);

`ifdef QUANT_DC_BYPASS_EN
      bus.DCBYPASS = 1'b1;
      fill_random(); blk_w[15] = -500;
      send_block(0, 1'b1, 0, -1);
      bus.DCBYPASS = 1'b0;
      fill_random(); send_block(10, 1'b0, 0, -1);
`endif

      repeat (8) @(posedge CLK);
      #1;
      check_value("drain_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
